// File: rtl/riscv_enc_pkg.sv
// Shared RV32I encoding definitions: format codes, opcodes, field bundle and packer.
package riscv_enc_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned FMT_W = 3;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned REG_W = 5;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;
    localparam int unsigned CNT_W = 8;

    localparam logic [FMT_W-1:0] FMT_R = 3'd0;
    localparam logic [FMT_W-1:0] FMT_I = 3'd1;
    localparam logic [FMT_W-1:0] FMT_S = 3'd2;
    localparam logic [FMT_W-1:0] FMT_B = 3'd3;
    localparam logic [FMT_W-1:0] FMT_U = 3'd4;
    localparam logic [FMT_W-1:0] FMT_J = 3'd5;

    localparam logic [OPC_W-1:0] OP_LOAD   = 7'h03;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'h13;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'h17;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'h23;
    localparam logic [OPC_W-1:0] OP        = 7'h33;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'h37;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'h63;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'h67;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'h6f;

    typedef struct packed {
        logic [FMT_W-1:0] fmt;
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [F3_W-1:0]  func3;
        logic [F7_W-1:0]  func7;
        logic [XLEN-1:0]  imm;
    } enc_bundle_t;

    // Pack a field bundle into an instruction word; illegal formats yield zero.
    function automatic logic [XLEN-1:0] pack_instr(input enc_bundle_t b);
        logic [XLEN-1:0] w;
        w = '0;
        case (b.fmt)
            FMT_R: w = {b.func7, b.rs2, b.rs1, b.func3, b.rd, b.opcode};
            FMT_I: w = {b.imm[11:0], b.rs1, b.func3, b.rd, b.opcode};
            FMT_S: w = {b.imm[11:5], b.rs2, b.rs1, b.func3, b.imm[4:0], b.opcode};
            FMT_B: w = {b.imm[12], b.imm[10:5], b.rs2, b.rs1, b.func3,
                        b.imm[4:1], b.imm[11], b.opcode};
            FMT_U: w = {b.imm[31:12], b.rd, b.opcode};
            FMT_J: w = {b.imm[20], b.imm[10:1], b.imm[11], b.imm[19:12], b.rd, b.opcode};
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_imm_check.sv
// Combinational check: flags bundles whose immediate cannot be encoded exactly.
module instr_imm_check
    import riscv_enc_pkg::*;
(
    input  logic [FMT_W-1:0] fmt,
    input  logic [XLEN-1:0]  imm,
    output logic             err_c
);

    localparam logic signed [XLEN-1:0] I_MIN = -32'sd2048;
    localparam logic signed [XLEN-1:0] I_MAX = 32'sd2047;
    localparam logic signed [XLEN-1:0] B_MIN = -32'sd4096;
    localparam logic signed [XLEN-1:0] B_MAX = 32'sd4094;
    localparam logic signed [XLEN-1:0] J_MIN = -32'sd1048576;
    localparam logic signed [XLEN-1:0] J_MAX = 32'sd1048574;

    logic signed [XLEN-1:0] simm;
    assign simm = signed'(imm);

    // Range and alignment rules per format; unknown formats always error.
    always_comb begin
        err_c = 1'b0;
        case (fmt)
            FMT_R:        err_c = 1'b0;
            FMT_I, FMT_S: err_c = (simm < I_MIN) || (simm > I_MAX);
            FMT_B:        err_c = (simm < B_MIN) || (simm > B_MAX) || imm[0];
            FMT_U:        err_c = (imm[11:0] != 12'h000);
            FMT_J:        err_c = (simm < J_MIN) || (simm > J_MAX) || imm[0];
            default:      err_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32I encoder: S1 holds the bundle plus range flag, S2 holds the packed word.
module instr_encoder
    import riscv_enc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FMT_W-1:0]  fmt,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [REG_W-1:0]  rd,
    input  logic [REG_W-1:0]  rs1,
    input  logic [REG_W-1:0]  rs2,
    input  logic [F3_W-1:0]   func3,
    input  logic [F7_W-1:0]   func7,
    input  logic [XLEN-1:0]   imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   instr,
    output logic              enc_err,
    output logic [CNT_W-1:0]  err_count
);

    enc_bundle_t bundle_in;
    enc_bundle_t s1_bundle;
    logic        s1_valid;
    logic        s1_err;
    logic        in_err_c;
    logic        s2_advance_c;

    assign bundle_in = '{fmt: fmt, opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                         func3: func3, func7: func7, imm: imm};

    instr_imm_check u_imm_check (
        .fmt   (fmt),
        .imm   (imm),
        .err_c (in_err_c)
    );

    // S2 loads when empty or draining; S1 moves in lockstep with it.
    assign s2_advance_c = !out_valid || out_ready;
    assign in_ready     = !s1_valid || s2_advance_c;

    // Stage 1: capture bundle and its error flag on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_bundle <= '0;
            s1_err    <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_bundle <= bundle_in;
                s1_err    <= in_err_c;
            end
        end
    end

    // Stage 2: pack the word; output holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            instr     <= '0;
            enc_err   <= 1'b0;
        end else if (s2_advance_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                instr   <= pack_instr(s1_bundle);
                enc_err <= s1_err;
            end
        end
    end

    // Saturating count of delivered erroneous words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (out_valid && out_ready && enc_err && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with hand-computed expected words.
module tb_instr_encoder;
    import riscv_enc_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [FMT_W-1:0]  fmt;
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [F3_W-1:0]   func3;
    logic [F7_W-1:0]   func7;
    logic [XLEN-1:0]   imm;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   instr;
    logic              enc_err;
    logic [CNT_W-1:0]  err_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [31:0] q_instr[$];
    logic        q_err[$];
    int          q_cyc[$];

    instr_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .func3(func3), .func7(func7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
        .enc_err(enc_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Cycle counter and delivered-word capture.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && out_valid && out_ready) begin
            q_instr.push_back(instr);
            q_err.push_back(enc_err);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a bundle at a negedge and hold it until accepted (bounded).
    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im);
        logic acc;
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        func3 = f3; func7 = f7; imm = im;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!acc) check("send_accept", 32'(acc), 32'd1);
    endtask

    // Wait (bounded) for the next delivered word and compare it.
    task automatic expect_word(input string tag, input logic [31:0] ei, input logic ee,
                               output int c);
        c = -1;
        for (int i = 0; i < 50 && q_instr.size() == 0; i++) @(negedge clk);
        check({tag, "_arrived"}, 32'(q_instr.size() != 0), 32'd1);
        if (q_instr.size() != 0) begin
            check({tag, "_instr"}, q_instr.pop_front(), ei);
            check({tag, "_err"}, 32'(q_err.pop_front()), 32'(ee));
            c = q_cyc.pop_front();
        end
    endtask

    initial begin
        int c0, c1, c2, idx;
        logic a;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
        func3 = '0; func7 = '0; imm = '0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_enc_err", 32'(enc_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // R-type with latency check
        fmt = FMT_R; opcode = 7'h33; rd = 5'd1; rs1 = 5'd1; rs2 = 5'd2;
        func3 = 3'd0; func7 = 7'd0; imm = 32'd0; in_valid = 1'b1;
        check("r_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("r_lat1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("r_lat2_valid", 32'(out_valid), 32'd1);
        check("r_lat2_instr", instr, 32'h002080b3);
        expect_word("r_type", 32'h002080b3, 1'b0, c0);

        // I, I, J back-to-back
        send(FMT_I, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd1);
        send(FMT_I, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
        send(FMT_J, 7'h6f, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
        expect_word("i_addi2", 32'h00110113, 1'b0, c0);
        expect_word("i_addi1", 32'h00108093, 1'b0, c1);
        expect_word("j_neg4", 32'hffdff1ef, 1'b0, c2);
        check("b2b_gap1", 32'(c1 - c0), 32'd1);
        check("b2b_gap2", 32'(c2 - c1), 32'd1);

        // Range boundaries that must encode cleanly
        send(FMT_I, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047);
        send(FMT_I, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048);
        send(FMT_S, 7'h23, 5'd0, 5'd4, 5'd3, 3'd2, 7'd0, -32'sd1);
        send(FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094);
        send(FMT_J, 7'h6f, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd1048576);
        send(FMT_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        expect_word("i_max", 32'h7ff00013, 1'b0, c0);
        expect_word("i_min", 32'h80000013, 1'b0, c0);
        expect_word("s_neg1", 32'hfe322fa3, 1'b0, c0);
        expect_word("b_max", 32'h7e000fe3, 1'b0, c0);
        expect_word("j_min", 32'h8000006f, 1'b0, c0);
        expect_word("u_lui", 32'h123452b7, 1'b0, c0);

        // Error cases
        send(FMT_I, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        send(FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        send(3'd6, 7'h33, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        expect_word("err_i_2048", 32'h80000013, 1'b1, c0);
        expect_word("err_b_odd", 32'h00000163, 1'b1, c0);
        expect_word("err_fmt6", 32'h00000000, 1'b1, c0);
        @(negedge clk);
        check("err_count_3", 32'(err_count), 32'd3);

        // Backpressure: stall for 5 cycles with input always offered
        out_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            fmt = FMT_R; opcode = 7'h33; rd = 5'(idx + 5); rs1 = '0; rs2 = '0;
            func3 = '0; func7 = '0; imm = '0; in_valid = 1'b1;
            if (out_valid) check("bp_hold_instr", instr, 32'h000002b3);
            a = in_ready;
            @(negedge clk);
            if (a) idx++;
        end
        check("bp_accepts", 32'(idx), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_instr", instr, 32'h000002b3);
        check("bp_no_transfer", 32'(q_instr.size()), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        expect_word("bp_w0", 32'h000002b3, 1'b0, c0);
        expect_word("bp_w1", 32'h00000333, 1'b0, c0);
        repeat (3) @(negedge clk);
        check("bp_no_dup", 32'(q_instr.size()), 32'd0);

        // Reset with both stages full
        out_ready = 1'b0;
        send(FMT_R, 7'h33, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        send(3'd7, 7'h33, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("pre_rst_err_count", 32'(err_count), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send(FMT_R, 7'h33, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        expect_word("post_rst_r", 32'h002080b3, 1'b0, c0);
        repeat (3) @(negedge clk);
        check("post_rst_no_stale", 32'(q_instr.size()), 32'd0);

        // Saturation after 260 erroneous words
        for (int k = 0; k < 260; k++) send(3'd6, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (5) @(negedge clk);
        check("sat_delivered", 32'(q_instr.size()), 32'd260);
        check("sat_err_count", 32'(err_count), 32'd255);
        q_instr.delete(); q_err.delete(); q_cyc.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
